// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pulse-handshake memory port between clients A
// and B. Each client's request is latched, grants alternate round-robin, the
// memory handshake is sequenced with a timeout, and a done pulse (with error
// on timeout) is returned. Dropped requests raise a one-cycle overrun pulse.
module mem_port_arbiter #(
    parameter int DATAW   = 16,
    parameter int ADDRW   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             a_request,
    input  logic             a_write,
    input  logic [ADDRW-1:0] a_addr,
    input  logic [DATAW-1:0] a_wdata,
    output logic [DATAW-1:0] a_rdata,
    output logic             a_done,
    output logic             a_error,
    output logic             a_overrun,
    input  logic             b_request,
    input  logic             b_write,
    input  logic [ADDRW-1:0] b_addr,
    input  logic [DATAW-1:0] b_wdata,
    output logic [DATAW-1:0] b_rdata,
    output logic             b_done,
    output logic             b_error,
    output logic             b_overrun,
    output logic             mem_request,
    output logic             mem_write,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata,
    input  logic             mem_done,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Last WAIT cycle before the transaction is declared timed out.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t           state, state_n;
    logic             a_pend, b_pend;     // latched, not yet issued
    logic             a_cbusy, b_cbusy;   // captured, done not yet returned
    logic             a_lw, b_lw;
    logic [ADDRW-1:0] a_laddr, b_laddr;
    logic [DATAW-1:0] a_lwdata, b_lwdata;
    logic             ptr;                // 0: A wins a tie, 1: B wins a tie
    logic             gnt;                // client owning the port (1 = B)
    logic [7:0]       cnt;
    logic             a_acc, b_acc;
    logic             grant_go, gnt_n, done_ok, done_to;

    // Acceptance, grant decision and next state.
    always_comb begin
        a_acc    = a_request && (!a_cbusy || a_done);
        b_acc    = b_request && (!b_cbusy || b_done);
        state_n  = state;
        grant_go = 1'b0;
        gnt_n    = gnt;
        done_ok  = 1'b0;
        done_to  = 1'b0;
        case (state)
            IDLE: begin
                if (a_pend || b_pend) begin
                    grant_go = 1'b1;
                    state_n  = ISSUE;
                    if (a_pend && b_pend) gnt_n = ptr;
                    else                  gnt_n = b_pend;
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (mem_done) begin
                    done_ok = 1'b1;
                    state_n = RESP;
                end else if (cnt == TO_LAST) begin
                    done_to = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!nRst) state <= IDLE;
        else       state <= state_n;
    end

    // Client request capture, busy tracking and overrun pulses.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            a_pend <= 1'b0;  a_cbusy <= 1'b0;  a_overrun <= 1'b0;
            a_lw   <= 1'b0;  a_laddr <= '0;    a_lwdata  <= '0;
            b_pend <= 1'b0;  b_cbusy <= 1'b0;  b_overrun <= 1'b0;
            b_lw   <= 1'b0;  b_laddr <= '0;    b_lwdata  <= '0;
        end else begin
            if (a_acc) begin
                a_pend   <= 1'b1;
                a_lw     <= a_write;
                a_laddr  <= a_addr;
                a_lwdata <= a_wdata;
            end else if (state == ISSUE && !gnt) begin
                a_pend <= 1'b0;
            end
            if (b_acc) begin
                b_pend   <= 1'b1;
                b_lw     <= b_write;
                b_laddr  <= b_addr;
                b_lwdata <= b_wdata;
            end else if (state == ISSUE && gnt) begin
                b_pend <= 1'b0;
            end
            a_cbusy   <= a_acc || (a_cbusy && !a_done);
            b_cbusy   <= b_acc || (b_cbusy && !b_done);
            a_overrun <= a_request && a_cbusy && !a_done;
            b_overrun <= b_request && b_cbusy && !b_done;
        end
    end

    // Memory port drive, grant owner, round-robin pointer and timeout counter.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            mem_request <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            gnt         <= 1'b0;
            ptr         <= 1'b0;
            cnt         <= '0;
            busy        <= 1'b0;
        end else begin
            mem_request <= grant_go;
            busy        <= (state_n != IDLE);
            if (grant_go) begin
                gnt       <= gnt_n;
                ptr       <= !gnt_n;
                mem_write <= gnt_n ? b_lw     : a_lw;
                mem_addr  <= gnt_n ? b_laddr  : a_laddr;
                mem_wdata <= gnt_n ? b_lwdata : a_lwdata;
            end
            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 8'd1;
        end
    end

    // Completion pulses, error flags and read data return.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            a_done <= 1'b0;  a_error <= 1'b0;  a_rdata <= '0;
            b_done <= 1'b0;  b_error <= 1'b0;  b_rdata <= '0;
        end else begin
            a_done  <= (done_ok || done_to) && !gnt;
            b_done  <= (done_ok || done_to) && gnt;
            a_error <= done_to && !gnt;
            b_error <= done_to && gnt;
            if (done_ok && !mem_write && !gnt) a_rdata <= mem_rdata;
            if (done_ok && !mem_write && gnt)  b_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed transaction table,
// hand-written multi-cycle sequences, and a randomized run against a
// transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        a_request = 1'b0, a_write = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0;
    logic [15:0] a_rdata;
    logic        a_done, a_error, a_overrun;
    logic        b_request = 1'b0, b_write = 1'b0;
    logic [15:0] b_addr = '0, b_wdata = '0;
    logic [15:0] b_rdata;
    logic        b_done, b_error, b_overrun;
    logic        mem_request, mem_write;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_done = 1'b0;
    logic        busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.DATAW(16), .ADDRW(16), .TIMEOUT(TO)) dut (
        .clk(clk), .nRst(nRst),
        .a_request(a_request), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_done(a_done), .a_error(a_error), .a_overrun(a_overrun),
        .b_request(b_request), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_done(b_done), .b_error(b_error), .b_overrun(b_overrun),
        .mem_request(mem_request), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          cli;        // 0 = A, 1 = B
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          dly;        // mem_done this many cycles after mem_request; 0 = never
        logic [15:0] rdata;      // data the memory presents
        bit          exp_err;
        logic [15:0] exp_rdata;  // client rdata after the done pulse
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        a_request = 1'b0; b_request = 1'b0; mem_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, {13'b0, a_done, a_error, a_overrun, a_rdata}, 32'h0);
        chk({tag, "_b"}, {13'b0, b_done, b_error, b_overrun, b_rdata}, 32'h0);
        chk({tag, "_mem"}, {14'b0, mem_request, mem_write, mem_addr}, 32'h0);
        chk({tag, "_wd_busy"}, {15'b0, busy, mem_wdata}, 32'h0);
    endtask

    // One isolated transaction with exact latency checks.
    task automatic run_txn(input vec_t v);
        int  t, r, expc;
        bit  seen_req, seen_done, ok;
        logic d, o, e;
        logic [15:0] rd;
        @(negedge clk);
        if (v.cli) begin b_request = 1'b1; b_write = v.wr; b_addr = v.addr; b_wdata = v.wdata; end
        else       begin a_request = 1'b1; a_write = v.wr; a_addr = v.addr; a_wdata = v.wdata; end
        t = cyc; r = 0; seen_req = 0; seen_done = 0;
        ok = (v.dly != 0) && (v.dly <= TO);
        for (int k = 0; k < 40 && !seen_done; k++) begin
            @(negedge clk);
            drive_idle();
            mem_rdata = 16'hDEAD;
            if (mem_request) begin
                chk("txn_req_lat", 32'(cyc - t), 32'd2);
                chk("txn_mem_write", 32'(mem_write), 32'(v.wr));
                chk("txn_mem_addr", 32'(mem_addr), 32'(v.addr));
                if (v.wr) chk("txn_mem_wdata", 32'(mem_wdata), 32'(v.wdata));
                chk("txn_busy", 32'(busy), 32'd1);
                r = cyc; seen_req = 1;
            end
            if (seen_req && v.dly != 0 && cyc == r + v.dly) begin
                mem_done = 1'b1; mem_rdata = v.rdata;
            end
            d  = v.cli ? b_done : a_done;
            o  = v.cli ? a_done : b_done;
            e  = v.cli ? b_error : a_error;
            rd = v.cli ? b_rdata : a_rdata;
            if (o) chk("txn_wrong_done", 32'(o), 32'd0);
            if (d) begin
                seen_done = 1;
                expc = ok ? r + v.dly + 1 : r + TO + 1;
                chk("txn_done_cyc", 32'(cyc), 32'(expc));
                chk("txn_error", 32'(e), 32'(v.exp_err));
                chk("txn_rdata", 32'(rd), 32'(v.exp_rdata));
                chk("txn_addr_held", 32'(mem_addr), 32'(v.addr));
            end
        end
        if (!seen_done) chk("txn_done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        drive_idle();
        chk("txn_idle_busy", 32'(busy), 32'd0);
    endtask

    // Both clients request together and re-request on each done pulse.
    task automatic run_simul();
        int na_req = 1, nb_req = 1, na_dn = 0, nb_dn = 0, n = 0, r = -100, novr = 0;
        logic [15:0] acur = 16'h0100, bcur = 16'h0200, mad = '0;
        @(negedge clk);
        a_request = 1'b1; a_write = 1'b0; a_addr = acur;
        b_request = 1'b1; b_write = 1'b0; b_addr = bcur;
        for (int i = 0; i < 300 && (na_dn < 4 || nb_dn < 4); i++) begin
            @(negedge clk);
            drive_idle();
            novr += int'(a_overrun) + int'(b_overrun);
            if (mem_request) begin
                chk("simul_order", 32'(mem_addr[9]), 32'(n % 2));
                n++; r = cyc; mad = mem_addr;
            end
            if (cyc == r + 2) begin mem_done = 1'b1; mem_rdata = mad ^ 16'h5A5A; end
            if (a_done) begin
                chk("simul_a_rdata", 32'(a_rdata), 32'(acur ^ 16'h5A5A));
                na_dn++;
                if (na_req < 4) begin acur = 16'(16'h0100 + na_req); a_request = 1'b1; a_addr = acur; na_req++; end
            end
            if (b_done) begin
                chk("simul_b_rdata", 32'(b_rdata), 32'(bcur ^ 16'h5A5A));
                nb_dn++;
                if (nb_req < 4) begin bcur = 16'(16'h0200 + nb_req); b_request = 1'b1; b_addr = bcur; nb_req++; end
            end
        end
        chk("simul_a_dones", 32'(na_dn), 32'd4);
        chk("simul_b_dones", 32'(nb_dn), 32'd4);
        chk("simul_grants", 32'(n), 32'd8);
        chk("simul_no_overrun", 32'(novr), 32'd0);
    endtask

    // A second A request while the first is in flight is dropped.
    task automatic run_overrun();
        int nreq = 0, novr = 0, ndone = 0, r = -100, ovr_cyc = -1;
        @(negedge clk);
        a_request = 1'b1; a_write = 1'b0; a_addr = 16'h0001;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive_idle();
            if (mem_request) begin
                nreq++; r = cyc;
                chk("ovr_mem_addr", 32'(mem_addr), 32'h1);
            end
            if (cyc == r + 1) begin a_request = 1'b1; a_addr = 16'h0002; end
            if (cyc == r + 4) begin mem_done = 1'b1; mem_rdata = 16'h1111; end
            if (a_overrun) begin novr++; ovr_cyc = cyc; end
            if (a_done) begin
                ndone++;
                chk("ovr_addr_held", 32'(mem_addr), 32'h1);
                chk("ovr_rdata", 32'(a_rdata), 32'h1111);
            end
        end
        chk("ovr_pulses", 32'(novr), 32'd1);
        chk("ovr_pulse_cyc", 32'(ovr_cyc), 32'(r + 2));
        chk("ovr_dones", 32'(ndone), 32'd1);
        chk("ovr_mem_reqs", 32'(nreq), 32'd1);
    endtask

    // Reset while waiting on memory abandons the transaction silently.
    task automatic run_reset_wait();
        bit seen = 0;
        int ndone = 0;
        @(negedge clk);
        a_request = 1'b1; a_write = 1'b0; a_addr = 16'h0077;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            drive_idle();
            if (mem_request) seen = 1;
        end
        if (!seen) chk("rstw_req_timeout", 32'd0, 32'd1);
        @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        chk_zero("rstw");
        mem_done = 1'b1; mem_rdata = 16'hCAFE;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_done = 1'b0;
            ndone += int'(a_done) + int'(b_done) + int'(busy);
        end
        chk("rstw_late_done_ignored", 32'(ndone), 32'd0);
        chk("rstw_rdata", 32'(a_rdata), 32'h0);
    endtask

    // Random traffic against a transaction-level model.
    task automatic run_random(input int ncyc);
        bit          pend[2], iss[2], twr[2], eovr[2];
        int          acc[2];
        logic [15:0] tad[2], twd[2], mrd[2];
        bit          act, acli, awr, eerr, ptr, c0, c1, ec, dn;
        int          rc, dl, edc, k;
        logic [15:0] ard;
        logic        req_w;
        logic [15:0] req_a, req_d;
        for (int c = 0; c < 2; c++) begin
            pend[c] = 0; iss[c] = 0; twr[c] = 0; eovr[c] = 0; acc[c] = 0;
            tad[c] = '0; twd[c] = '0; mrd[c] = '0;
        end
        act = 0; acli = 0; awr = 0; eerr = 0; ptr = 0; rc = 0; dl = 0; edc = 0; ard = '0;
        for (int i = 0; i < ncyc + 60; i++) begin
            @(negedge clk);
            k = cyc;
            drive_idle();
            mem_rdata = 16'($urandom);
            chk("rnd_ovr_a", 32'(a_overrun), 32'(eovr[0]));
            chk("rnd_ovr_b", 32'(b_overrun), 32'(eovr[1]));
            eovr[0] = 0; eovr[1] = 0;
            if (mem_request) begin
                c0 = pend[0] && !iss[0] && (acc[0] <= k - 2);
                c1 = pend[1] && !iss[1] && (acc[1] <= k - 2);
                if (act || !(c0 || c1)) begin
                    chk("rnd_req_legal", 32'd0, 32'd1);
                end else begin
                    ec = (c0 && c1) ? ptr : c1;
                    chk("rnd_mem_addr", 32'(mem_addr), 32'(tad[ec]));
                    chk("rnd_mem_write", 32'(mem_write), 32'(twr[ec]));
                    chk("rnd_mem_wdata", 32'(mem_wdata), 32'(twd[ec]));
                    iss[ec] = 1; ptr = !ec; act = 1; acli = ec; awr = twr[ec];
                    rc = k; dl = $urandom_range(1, 12); ard = 16'($urandom);
                    if (dl <= TO) begin edc = k + dl + 1;  eerr = 0; end
                    else          begin edc = k + TO + 1;  eerr = 1; end
                end
            end
            if (act && dl <= TO && k == rc + dl) begin
                mem_done = 1'b1; mem_rdata = ard;
            end else if (!act && $urandom_range(0, 7) == 0) begin
                mem_done = 1'b1;
            end
            for (int c = 0; c < 2; c++) begin
                dn = act && (acli == c) && (k == edc);
                if (dn && !eerr && !awr) mrd[c] = ard;
                chk("rnd_done", 32'(c ? b_done : a_done), 32'(dn));
                chk("rnd_error", 32'(c ? b_error : a_error), 32'(dn && eerr));
                chk("rnd_rdata", 32'(c ? b_rdata : a_rdata), 32'(mrd[c]));
                if (dn) begin pend[c] = 0; act = 0; end
            end
            if (i < ncyc) begin
                for (int c = 0; c < 2; c++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_w = 1'($urandom); req_a = 16'($urandom); req_d = 16'($urandom);
                        if (c == 0) begin a_request = 1'b1; a_write = req_w; a_addr = req_a; a_wdata = req_d; end
                        else        begin b_request = 1'b1; b_write = req_w; b_addr = req_a; b_wdata = req_d; end
                        if (!pend[c]) begin
                            pend[c] = 1; iss[c] = 0; acc[c] = k;
                            twr[c] = req_w; tad[c] = req_a; twd[c] = req_d;
                        end else begin
                            eovr[c] = 1;
                        end
                    end
                end
            end
        end
        chk("rnd_drain_a", 32'(pend[0]), 32'd0);
        chk("rnd_drain_b", 32'(pend[1]), 32'd0);
    endtask

    vec_t vecs[8];
    vec_t vafter;

    initial begin
        vecs[0] = '{0, 0, 16'h0010, 16'h0000, 3, 16'hBEEF, 0, 16'hBEEF};
        vecs[1] = '{1, 1, 16'h0020, 16'h1234, 1, 16'h9999, 0, 16'h0000};
        vecs[2] = '{0, 0, 16'h0030, 16'h0000, 1, 16'h5555, 0, 16'h5555};
        vecs[3] = '{1, 0, 16'h0040, 16'h0000, 8, 16'hA5A5, 0, 16'hA5A5};
        vecs[4] = '{0, 0, 16'h0050, 16'h0000, 0, 16'h0000, 1, 16'h5555};
        vecs[5] = '{0, 1, 16'h0060, 16'hFFFF, 2, 16'h1111, 0, 16'h5555};
        vecs[6] = '{1, 0, 16'hFFFF, 16'h0000, 9, 16'h7777, 1, 16'hA5A5};
        vecs[7] = '{1, 0, 16'h0001, 16'h0000, 2, 16'h0F0F, 0, 16'h0F0F};
        vafter  = '{0, 0, 16'h0099, 16'h0000, 2, 16'h2222, 0, 16'h2222};

        do_reset();
        chk_zero("reset");
        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        do_reset();
        run_simul();
        run_overrun();
        run_reset_wait();
        run_txn(vafter);

        do_reset();
        run_random(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
